sync_fifo_flags: RTL and testbench

Parametrised synchronous single-clock FIFO and the next generation of the team's basic sync FIFO.
- All DEPTH entries are usable, with an occupancy count tracked separately from the pointers.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a compile-time first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer datapath stages in the same clock domain.

---
 rtl/sync_fifo_flags_if.sv | 38 +++
 rtl/sync_fifo_flags.sv | 114 +++++++++++
 tb/tb_sync_fifo_flags.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags: write side, read side, status and error flags.
// No latency of its own; purely a grouping of wires.
// Backpressure is carried by full/empty and the almost_* flags driven by the FIFO.
interface sync_fifo_flags_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  // Side that drives requests and consumes data/status.
  modport master (
    output flush, wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  // The FIFO itself.
  modport slave (
    input  flush, wr_en, din, rd_en, clr_err,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky errors, flush, optional FWFT.
// Latency: FWFT=0 data one cycle after an accepted read; FWFT=1 head word visible the cycle after its write.
// Backpressure: writes dropped while full, reads dropped while empty (both judged on start-of-cycle state); flush drops both.
module sync_fifo_flags #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              full_int;
  logic              empty_int;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_set;
  logic              udf_set;
  logic              ovf_q;
  logic              udf_q;

  // Flags decode the registered count, so they reflect an access one cycle later.
  assign full_int  = (cnt == FULL_CNT);
  assign empty_int = (cnt == '0);

  // Flush wins over both requests; full/empty are start-of-cycle so a same-cycle read never frees room for a write.
  assign wr_acc  = bus.wr_en & ~full_int  & ~bus.flush;
  assign rd_acc  = bus.rd_en & ~empty_int & ~bus.flush;
  assign ovf_set = bus.wr_en & full_int  & ~bus.flush;
  assign udf_set = bus.rd_en & empty_int & ~bus.flush;

  // Storage is deliberately left unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.din;
  end

  // Pointers wrap naturally at the power-of-two depth; count is kept apart so all DEPTH slots are usable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.clr_err) ovf_q <= 1'b0;
      if (udf_set)          udf_q <= 1'b1;
      else if (bus.clr_err) udf_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; rd_en acts as the pop.
      assign bus.dout       = mem[rd_ptr];
      assign bus.dout_valid = ~empty_int;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              dout_valid_q;

      // Registered read: one-cycle valid pulse per accepted read, data held between reads and across flush.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          dout_valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr];
        end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = dout_valid_q;
    end
  endgenerate

  assign bus.full         = full_int;
  assign bus.empty        = empty_int;
  assign bus.almost_full  = (cnt >= AF_CNT);
  assign bus.almost_empty = (cnt <= AE_CNT);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one standard-read instance and one FWFT instance, both DEPTH=16.
// Inputs change 1 time unit after a rising edge; outputs are checked there, away from the edge.
// Expected values are hand-derived constants and loop indices.
module tb_sync_fifo_flags;
  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  sync_fifo_flags_if #(.DATA_W(8), .DEPTH(16)) bus_s ();
  sync_fifo_flags_if #(.DATA_W(8), .DEPTH(16)) bus_f ();

  sync_fifo_flags #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  sync_fifo_flags #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (bus_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (bus_s.count !== 5'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", bus_s.count); end
    vectors++; if (bus_s.empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b expected 1", bus_s.empty); end
    vectors++; if (bus_s.full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b expected 0", bus_s.full); end
    vectors++; if (bus_s.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", bus_s.almost_empty); end
    vectors++; if (bus_s.almost_full !== 1'b0)  begin errors++; $display("FAIL reset_af: got %b expected 0", bus_s.almost_full); end
    vectors++; if (bus_s.dout !== 8'h00)     begin errors++; $display("FAIL reset_dout: got %h expected 00", bus_s.dout); end
    vectors++; if (bus_s.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b expected 0", bus_s.dout_valid); end
    vectors++; if (bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0)
      begin errors++; $display("FAIL reset_err: got ovf=%b udf=%b expected 0/0", bus_s.overflow, bus_s.underflow); end
    vectors++; if (bus_f.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_fwft_dvalid: got %b expected 0", bus_f.dout_valid); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 16; k++) begin
      bus_s.wr_en = 1'b1;
      bus_s.din   = 8'(k);
      step();
      vectors++; if (bus_s.count !== 5'(k)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, bus_s.count, k); end
      vectors++; if (bus_s.full !== (k == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", k, bus_s.full, k == 16); end
      vectors++; if (bus_s.almost_full !== (k >= 14)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", k, bus_s.almost_full, k >= 14); end
      vectors++; if (bus_s.almost_empty !== (k <= 2)) begin errors++; $display("FAIL fill_ae[%0d]: got %b expected %b", k, bus_s.almost_empty, k <= 2); end
    end
    bus_s.din = 8'hAA;
    step();
    bus_s.wr_en = 1'b0;
    vectors++; if (bus_s.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus_s.overflow); end
    vectors++; if (bus_s.count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d expected 16", bus_s.count); end
  endtask

  task automatic test_drain();
    bus_s.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      vectors++; if (bus_s.dout !== 8'(i + 1)) begin errors++; $display("FAIL drain_dout[%0d]: got %h expected %h", i, bus_s.dout, 8'(i + 1)); end
      vectors++; if (bus_s.dout_valid !== 1'b1) begin errors++; $display("FAIL drain_dvalid[%0d]: got %b expected 1", i, bus_s.dout_valid); end
    end
    bus_s.rd_en = 1'b0;
    step();
    vectors++; if (bus_s.empty !== 1'b1)      begin errors++; $display("FAIL drain_empty: got %b expected 1", bus_s.empty); end
    vectors++; if (bus_s.dout_valid !== 1'b0) begin errors++; $display("FAIL drain_pulse: got %b expected 0", bus_s.dout_valid); end
    vectors++; if (bus_s.underflow !== 1'b0)  begin errors++; $display("FAIL drain_udf: got %b expected 0", bus_s.underflow); end
    bus_s.rd_en = 1'b1;
    step();
    bus_s.rd_en = 1'b0;
    vectors++; if (bus_s.underflow !== 1'b1)  begin errors++; $display("FAIL udf_set: got %b expected 1", bus_s.underflow); end
    vectors++; if (bus_s.dout_valid !== 1'b0) begin errors++; $display("FAIL udf_dvalid: got %b expected 0", bus_s.dout_valid); end
    bus_s.clr_err = 1'b1;
    step();
    bus_s.clr_err = 1'b0;
    vectors++; if (bus_s.underflow !== 1'b0 || bus_s.overflow !== 1'b0)
      begin errors++; $display("FAIL clr_err: got ovf=%b udf=%b expected 0/0", bus_s.overflow, bus_s.underflow); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      bus_s.wr_en = 1'b1;
      bus_s.din   = 8'(8'h20 + i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      bus_s.wr_en = 1'b1;
      bus_s.rd_en = 1'b1;
      bus_s.din   = 8'(8'h2A + i);
      step();
      vectors++; if (bus_s.dout !== 8'(8'h20 + i) || bus_s.dout_valid !== 1'b1)
        begin errors++; $display("FAIL wrap_dout[%0d]: got %h/%b expected %h/1", i, bus_s.dout, bus_s.dout_valid, 8'(8'h20 + i)); end
      vectors++; if (bus_s.count !== 5'd10) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 10", i, bus_s.count); end
    end
    bus_s.wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_s.rd_en = 1'b1;
      step();
      vectors++; if (bus_s.dout !== 8'(8'h34 + i)) begin errors++; $display("FAIL wrap_tail[%0d]: got %h expected %h", i, bus_s.dout, 8'(8'h34 + i)); end
    end
    bus_s.rd_en = 1'b0;
    step();
    vectors++; if (bus_s.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", bus_s.empty); end
    vectors++; if (bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0)
      begin errors++; $display("FAIL wrap_err: got ovf=%b udf=%b expected 0/0", bus_s.overflow, bus_s.underflow); end
  endtask

  task automatic test_simul_empty();
    bus_s.wr_en = 1'b1;
    bus_s.rd_en = 1'b1;
    bus_s.din   = 8'h77;
    step();
    bus_s.wr_en = 1'b0;
    bus_s.rd_en = 1'b0;
    vectors++; if (bus_s.count !== 5'd1)      begin errors++; $display("FAIL simul_count: got %0d expected 1", bus_s.count); end
    vectors++; if (bus_s.underflow !== 1'b1)  begin errors++; $display("FAIL simul_udf: got %b expected 1", bus_s.underflow); end
    vectors++; if (bus_s.dout_valid !== 1'b0) begin errors++; $display("FAIL simul_dvalid: got %b expected 0", bus_s.dout_valid); end
    bus_s.clr_err = 1'b1;
    step();
    bus_s.clr_err = 1'b0;
    vectors++; if (bus_s.underflow !== 1'b0) begin errors++; $display("FAIL simul_clr: got %b expected 0", bus_s.underflow); end
    bus_s.rd_en = 1'b1;
    step();
    bus_s.rd_en = 1'b0;
    vectors++; if (bus_s.dout !== 8'h77) begin errors++; $display("FAIL simul_read: got %h expected 77", bus_s.dout); end
  endtask

  task automatic test_fwft();
    bus_f.wr_en = 1'b1;
    bus_f.din   = 8'h5A;
    step();
    bus_f.wr_en = 1'b0;
    vectors++; if (bus_f.dout !== 8'h5A || bus_f.dout_valid !== 1'b1)
      begin errors++; $display("FAIL fwft_first: got %h/%b expected 5a/1", bus_f.dout, bus_f.dout_valid); end
    bus_f.wr_en = 1'b1;
    bus_f.din   = 8'h5B;
    step();
    bus_f.wr_en = 1'b0;
    vectors++; if (bus_f.dout !== 8'h5A) begin errors++; $display("FAIL fwft_hold: got %h expected 5a", bus_f.dout); end
    bus_f.rd_en = 1'b1;
    step();
    vectors++; if (bus_f.dout !== 8'h5B || bus_f.dout_valid !== 1'b1)
      begin errors++; $display("FAIL fwft_pop: got %h/%b expected 5b/1", bus_f.dout, bus_f.dout_valid); end
    step();
    bus_f.rd_en = 1'b0;
    vectors++; if (bus_f.empty !== 1'b1 || bus_f.dout_valid !== 1'b0)
      begin errors++; $display("FAIL fwft_empty: got empty=%b dvalid=%b expected 1/0", bus_f.empty, bus_f.dout_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      bus_s.wr_en = 1'b1;
      bus_s.din   = 8'(8'h40 + i);
      step();
    end
    vectors++; if (bus_s.count !== 5'd5) begin errors++; $display("FAIL flush_pre: got %0d expected 5", bus_s.count); end
    bus_s.flush = 1'b1;
    bus_s.rd_en = 1'b1;
    bus_s.din   = 8'hEE;
    step();
    bus_s.flush = 1'b0;
    bus_s.wr_en = 1'b0;
    bus_s.rd_en = 1'b0;
    vectors++; if (bus_s.count !== 5'd0 || bus_s.empty !== 1'b1)
      begin errors++; $display("FAIL flush_clear: got count=%0d empty=%b expected 0/1", bus_s.count, bus_s.empty); end
    vectors++; if (bus_s.dout !== 8'h77 || bus_s.dout_valid !== 1'b0)
      begin errors++; $display("FAIL flush_dout: got %h/%b expected 77/0", bus_s.dout, bus_s.dout_valid); end
    vectors++; if (bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0)
      begin errors++; $display("FAIL flush_err: got ovf=%b udf=%b expected 0/0", bus_s.overflow, bus_s.underflow); end
    bus_s.wr_en = 1'b1;
    bus_s.din   = 8'h50;
    step();
    bus_s.wr_en = 1'b0;
    bus_s.rd_en = 1'b1;
    step();
    bus_s.rd_en = 1'b0;
    vectors++; if (bus_s.dout !== 8'h50) begin errors++; $display("FAIL flush_after: got %h expected 50", bus_s.dout); end
  endtask

  task automatic test_rst_async();
    bus_s.wr_en = 1'b1;
    bus_s.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_s.din = 8'(8'h60 + i);
      step();
    end
    vectors++; if (bus_s.dout !== 8'h61 || bus_s.dout_valid !== 1'b1 || bus_s.underflow !== 1'b1)
      begin errors++; $display("FAIL burst_pre: got %h/%b udf=%b expected 61/1/1", bus_s.dout, bus_s.dout_valid, bus_s.underflow); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus_s.count !== 5'd0 || bus_s.empty !== 1'b1 || bus_s.full !== 1'b0)
      begin errors++; $display("FAIL arst_count: got count=%0d empty=%b full=%b expected 0/1/0", bus_s.count, bus_s.empty, bus_s.full); end
    vectors++; if (bus_s.dout !== 8'h00 || bus_s.dout_valid !== 1'b0)
      begin errors++; $display("FAIL arst_dout: got %h/%b expected 00/0", bus_s.dout, bus_s.dout_valid); end
    vectors++; if (bus_s.underflow !== 1'b0 || bus_s.almost_empty !== 1'b1)
      begin errors++; $display("FAIL arst_flags: got udf=%b ae=%b expected 0/1", bus_s.underflow, bus_s.almost_empty); end
    bus_s.wr_en = 1'b0;
    bus_s.rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    bus_s.flush = 1'b0; bus_s.wr_en = 1'b0; bus_s.rd_en = 1'b0; bus_s.clr_err = 1'b0; bus_s.din = '0;
    bus_f.flush = 1'b0; bus_f.wr_en = 1'b0; bus_f.rd_en = 1'b0; bus_f.clr_err = 1'b0; bus_f.din = '0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_empty();
    test_fwft();
    test_flush();
    test_rst_async();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
